// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard/stall sequencer.
package hazard_stall_controller_pkg;
  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} hsc_state_e;

  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;
endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_count <= '0;
    else if (inc_i && (r_count != {W{1'b1}}))
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
  end

  assign count_o = r_count;
endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// mul/div EX occupancy and taken-branch IF/ID flush, with perf counters.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_IDX_W-1:0] IDRS1_i,
  input  logic [REG_IDX_W-1:0] IDRS2_i,
  input  logic                 IDUsesRS2_i,
  input  logic                 EXMemRead_i,
  input  logic [REG_IDX_W-1:0] EXRD_i,
  input  logic                 EXMulDiv_i,
  input  logic                 BranchTaken_i,
  output logic                 PCWrite_o,
  output logic                 IFIDWrite_o,
  output logic                 IFIDFlush_o,
  output logic                 IDEXBubble_o,
  output logic                 EXHold_o,
  output logic                 MDStart_o,
  output logic [CNT_W-1:0]     StallCycles_o,
  output logic [CNT_W-1:0]     FlushCount_o
);
  // Entry covers the first hold cycle, so the wait counts the remaining ones.
  localparam logic [3:0] MD_LOAD = (MD_LATENCY > 1) ? 4'(MD_LATENCY - 2) : 4'd0;
  localparam logic       MD_MULTI = (MD_LATENCY > 1);

  hsc_state_e r_state, w_state_nxt;
  logic [3:0] r_md_cnt, w_md_cnt_nxt;
  logic       w_md_entry, w_md_hold, w_load_use;

  assign w_md_entry = (r_state == RUN) && EXMulDiv_i && MD_MULTI;
  assign w_md_hold  = w_md_entry || ((r_state == MD_WAIT) && (r_md_cnt != 4'd0));
  assign w_load_use = EXMemRead_i && (EXRD_i != REG_ZERO) &&
                      ((EXRD_i == IDRS1_i) || (IDUsesRS2_i && (EXRD_i == IDRS2_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= RUN;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFIDFlush_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    EXHold_o     = 1'b0;
    MDStart_o    = 1'b0;
    if (rst_i) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IFIDFlush_o  = 1'b1;
      IDEXBubble_o = 1'b1;
    end else begin
      // Start pulses even at single-cycle latency, where no hold follows.
      MDStart_o = (r_state == RUN) && EXMulDiv_i;
      if (w_md_entry) begin
        w_state_nxt  = MD_WAIT;
        w_md_cnt_nxt = MD_LOAD;
      end else if (r_state == MD_WAIT) begin
        if (r_md_cnt != 4'd0) w_md_cnt_nxt = r_md_cnt - 4'd1;
        else                  w_state_nxt  = RUN;
      end
      if (w_md_hold) begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        EXHold_o    = 1'b1;
      end else if (w_load_use) begin
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        IDEXBubble_o = 1'b1;
      end else if (BranchTaken_i) begin
        IFIDFlush_o = 1'b1;
      end
    end
  end

  logic w_stall_inc, w_flush_inc;
  assign w_stall_inc = !rst_i && !PCWrite_o;
  assign w_flush_inc = !rst_i && IFIDFlush_o;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_stall_inc), .count_o(StallCycles_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_flush_inc), .count_o(FlushCount_o)
  );
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed checks of hazard_stall_controller; second instance uses 4-bit counters.
module tb_hazard_stall_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, exrd;
  logic       uses2, memrd, muldiv, br;
  logic       pcw, ifidw, flush, bubble, hold, start;
  logic [31:0] stall_c, flush_c;
  logic        pcw4, ifidw4, flush4, bubble4, hold4, start4;
  logic [3:0]  stall_c4, flush_c4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .IDRS1_i(rs1), .IDRS2_i(rs2), .IDUsesRS2_i(uses2),
    .EXMemRead_i(memrd), .EXRD_i(exrd), .EXMulDiv_i(muldiv), .BranchTaken_i(br),
    .PCWrite_o(pcw), .IFIDWrite_o(ifidw), .IFIDFlush_o(flush), .IDEXBubble_o(bubble),
    .EXHold_o(hold), .MDStart_o(start), .StallCycles_o(stall_c), .FlushCount_o(flush_c)
  );

  hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .IDRS1_i(rs1), .IDRS2_i(rs2), .IDUsesRS2_i(uses2),
    .EXMemRead_i(memrd), .EXRD_i(exrd), .EXMulDiv_i(muldiv), .BranchTaken_i(br),
    .PCWrite_o(pcw4), .IFIDWrite_o(ifidw4), .IFIDFlush_o(flush4), .IDEXBubble_o(bubble4),
    .EXHold_o(hold4), .MDStart_o(start4), .StallCycles_o(stall_c4), .FlushCount_o(flush_c4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change at the falling edge, checks follow #1.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; exrd = 5'd0;
    uses2 = 1'b0; memrd = 1'b0; muldiv = 1'b0; br = 1'b0;
  endtask

  task automatic load_use_rs1();
    memrd = 1'b1; exrd = 5'd5; rs1 = 5'd5;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_pcw", 32'(pcw), 32'd0);
    check("rst_ifidw", 32'(ifidw), 32'd0);
    check("rst_flush", 32'(flush), 32'd1);
    check("rst_bubble", 32'(bubble), 32'd1);
    check("rst_hold", 32'(hold), 32'd0);
    step();
    rst = 1'b0; #1;
    check("post_rst_pcw", 32'(pcw), 32'd1);
    check("post_rst_stall", stall_c, 32'd0);
    check("post_rst_flushc", flush_c, 32'd0);

    // load-use via rs1
    load_use_rs1(); #1;
    check("lu_pcw", 32'(pcw), 32'd0);
    check("lu_ifidw", 32'(ifidw), 32'd0);
    check("lu_bubble", 32'(bubble), 32'd1);
    check("lu_hold", 32'(hold), 32'd0);
    step(); idle(); #1;
    check("lu_done_pcw", 32'(pcw), 32'd1);
    check("lu_stall", stall_c, 32'd1);

    // x0 and unused-rs2 filters, then rs2 actually used
    memrd = 1'b1; exrd = 5'd0; rs1 = 5'd0; #1;
    check("x0_pcw", 32'(pcw), 32'd1);
    step();
    exrd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; uses2 = 1'b0; #1;
    check("rs2_unused_pcw", 32'(pcw), 32'd1);
    uses2 = 1'b1; #1;
    check("rs2_used_bubble", 32'(bubble), 32'd1);
    step(); idle(); #1;
    check("filter_stall", stall_c, 32'd2);

    // mul/div occupancy, then back-to-back re-entry
    muldiv = 1'b1; #1;
    check("md0_start", 32'(start), 32'd1);
    check("md0_hold", 32'(hold), 32'd1);
    check("md0_pcw", 32'(pcw), 32'd0);
    step(); #1;
    check("md1_start", 32'(start), 32'd0);
    check("md1_hold", 32'(hold), 32'd1);
    step(); #1;
    check("md2_hold", 32'(hold), 32'd1);
    step(); #1;
    check("md3_hold", 32'(hold), 32'd0);
    check("md3_start", 32'(start), 32'd0);
    check("md3_pcw", 32'(pcw), 32'd1);
    step(); #1;
    check("md_stall", stall_c, 32'd5);
    check("b2b_start", 32'(start), 32'd1);
    check("b2b_hold", 32'(hold), 32'd1);
    step(); step(); muldiv = 1'b0; #1;
    check("b2b_last_hold", 32'(hold), 32'd1);
    step(); #1;
    check("b2b_exit_hold", 32'(hold), 32'd0);
    step(); #1;
    check("b2b_stall", stall_c, 32'd8);

    // branch loses to load-use, then flushes alone
    load_use_rs1(); br = 1'b1; #1;
    check("pri_bubble", 32'(bubble), 32'd1);
    check("pri_flush", 32'(flush), 32'd0);
    step(); memrd = 1'b0; #1;
    check("pri_flushc", flush_c, 32'd0);
    check("br_flush", 32'(flush), 32'd1);
    check("br_pcw", 32'(pcw), 32'd1);
    step(); idle(); #1;
    check("br_flushc", flush_c, 32'd1);
    check("br_stall", stall_c, 32'd9);

    // reset during MD_WAIT aborts the wait
    muldiv = 1'b1; step();
    rst = 1'b1; muldiv = 1'b0; #1;
    check("mdrst_flush", 32'(flush), 32'd1);
    check("mdrst_bubble", 32'(bubble), 32'd1);
    check("mdrst_hold", 32'(hold), 32'd0);
    step(); rst = 1'b0; #1;
    check("mdrst_after_hold", 32'(hold), 32'd0);
    check("mdrst_after_pcw", 32'(pcw), 32'd1);
    check("mdrst_stall", stall_c, 32'd0);
    check("mdrst_flushc", flush_c, 32'd0);
    check("mdrst_stall4", 32'(stall_c4), 32'd0);

    // 20 load-use stalls: narrow counter pins at 15
    load_use_rs1();
    for (int i = 0; i < 20; i++) step();
    idle(); #1;
    check("sat_stall4", 32'(stall_c4), 32'd15);
    check("sat_stall32", stall_c, 32'd20);
    step(); #1;
    check("sat_hold4", 32'(stall_c4), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Works alongside the EX-stage forwarding logic. It resolves the hazards forwarding cannot: load-use dependencies, multi-cycle mul/div occupancy of EX, and taken-branch flush at ID.
- Drives the write-enables and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Keeps stall and flush performance counters.

Parameters:
- MD_LATENCY, 4, cycles a mul/div instruction occupies EX (legal 1..15; 1 = no stall).
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- IDRS1_i  in  5  rs1 of instruction in ID
- IDRS2_i  in  5  rs2 of instruction in ID
- IDUsesRS2_i  in  1  ID instruction reads rs2 (R/S/B types)
- EXMemRead_i  in  1  instruction in EX is a load
- EXRD_i  in  5  rd of instruction in EX
- EXMulDiv_i  in  1  instruction in EX is mul/div
- BranchTaken_i  in  1  branch in ID resolved taken
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID write enable
- IFIDFlush_o  out  1  zero IF/ID (squash fetched instruction)
- IDEXBubble_o  out  1  load NOP into ID/EX
- EXHold_o  out  1  hold ID/EX contents, load NOP into EX/MEM
- MDStart_o  out  1  one-cycle start pulse to mul/div unit
- StallCycles_o  out  CNT_W  cycles with PCWrite_o=0 (excluding reset)
- FlushCount_o  out  CNT_W  number of IFIDFlush_o assertions (excluding reset)

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- State register has two states, RUN and MD_WAIT, plus a 4-bit down-counter md_cnt.
- While rst_i=1 the outputs are: PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=1, IDEXBubble_o=1, EXHold_o=0, MDStart_o=0.
- On the next edge with rst_i=1: state becomes RUN, md_cnt becomes 0, both counters become 0.
- Reset mid-MD_WAIT aborts the wait; the first post-reset cycle holds only if EXMulDiv_i=1.
- Hazard terms (combinational):
  - md_entry = state==RUN && EXMulDiv_i && MD_LATENCY>1.
  - md_hold = md_entry || (state==MD_WAIT && md_cnt!=0).
  - load_use = EXMemRead_i && EXRD_i!=0 && (EXRD_i==IDRS1_i || (IDUsesRS2_i && EXRD_i==IDRS2_i)).
- Priority is md_hold > load_use > BranchTaken_i. Exactly one action per cycle:
  - md_hold: PCWrite_o=0, IFIDWrite_o=0, EXHold_o=1. Other controls 0.
  - load_use: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1. Lasts one cycle only, because the bubble removes the load from EX.
  - BranchTaken_i: PCWrite_o=1, IFIDWrite_o=1, IFIDFlush_o=1.
  - None: PCWrite_o=1, IFIDWrite_o=1, other controls 0.
- A branch coinciding with load_use or md_hold is not flushed that cycle. It is re-evaluated when ID advances.
- MD sequencing:
  - On md_entry: MDStart_o=1, state becomes MD_WAIT, md_cnt becomes MD_LATENCY-2.
  - In MD_WAIT with md_cnt!=0: decrement. When md_cnt==0: EXHold_o=0 that cycle, state becomes RUN.
  - Result: EXHold_o is high for exactly MD_LATENCY-1 consecutive cycles from the entry cycle. The pipeline advances in cycle t+MD_LATENCY-1.
  - MD_LATENCY=1 never leaves RUN and never holds. MDStart_o still pulses on each EXMulDiv_i cycle in RUN.
  - EXMulDiv_i staying high during MD_WAIT is ignored. The same instruction is held, so there is no re-trigger.
  - Back-to-back mul/div: the exit cycle returns to RUN. The next instruction's EXMulDiv_i one cycle later triggers a fresh entry.
- Counters: each increments by 1 per qualifying cycle (PCWrite_o=0, or IFIDFlush_o=1, with rst_i=0). Each saturates at all-ones with no wrap.

Decomposition:
- Shared pipeline package:
  - State encoding (RUN=1'b0, MD_WAIT=1'b1).
  - Register-index width 5.
  - Constant REG_ZERO=5'd0.
- Sub-module sat_counter (parameter W; ports clk_i, rst_i, inc_i, count_o) is used twice.
- FSM, md_cnt and hazard decode live in the top module.

Test Plan:
- Load-use on rs1: EXMemRead_i=1, EXRD_i=5, IDRS1_i=5 for one cycle -> PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1 for 1 cycle; StallCycles_o=1.
- x0 and unused-rs2 filters:
  - EXRD_i=0 with IDRS1_i=0 -> no stall.
  - EXRD_i=7, IDRS2_i=7, IDUsesRS2_i=0 -> no stall.
- MD_LATENCY=4, EXMulDiv_i held for 4 cycles -> MDStart_o=1 in cycle 0 only; EXHold_o=1 in cycles 0-2, 0 in cycle 3; StallCycles_o=3; no re-trigger.
- Priority:
  - BranchTaken_i=1 together with load_use -> IDEXBubble_o=1, IFIDFlush_o=0, FlushCount_o unchanged.
  - Branch alone next cycle -> IFIDFlush_o=1, FlushCount_o=1.
- Reset mid-operation: rst_i=1 during cycle 1 of MD_WAIT -> the flush/bubble reset values apply while rst_i=1; the next cycle with EXMulDiv_i=0 gives EXHold_o=0, counters 0.
- Saturation: force counters near max (CNT_W=4 build), apply 20 stall cycles -> StallCycles_o stops at 15.
